// File: rtl/operand_combiner_if.sv
// Handshake bundle between the three-slot accumulator, the combiner and the
// next stage: operand triple plus done/consume upstream, result valid/ready
// downstream.
interface operand_combiner_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RWIDTH = 16
);
    logic [1:0]        op_mode;
    logic [WIDTH-1:0]  r0;
    logic [WIDTH-1:0]  r1;
    logic [WIDTH-1:0]  r2;
    logic              r0_valid;
    logic              r1_valid;
    logic              r2_valid;
    logic              done;
    logic              consume;
    logic              busy;
    logic [RWIDTH-1:0] result;
    logic              result_valid;
    logic              result_ready;

    // Upstream accumulator plus downstream consumer side.
    modport master (
        output op_mode, r0, r1, r2, r0_valid, r1_valid, r2_valid, done,
        output result_ready,
        input  consume, busy, result, result_valid
    );

    // Combiner side.
    modport slave (
        input  op_mode, r0, r1, r2, r0_valid, r1_valid, r2_valid, done,
        input  result_ready,
        output consume, busy, result, result_valid
    );
endinterface

// File: rtl/operand_combiner.sv
// Operand combiner: captures a complete operand triple from the accumulator,
// computes MAC / SUM / MIN / MAX (MAC via an iterative shift-add multiplier)
// and offers the zero-extended result on a valid/ready handshake.
module operand_combiner #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RWIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    operand_combiner_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, CALC, OUT} state_t;

    state_t            state_q, state_d;
    logic              capture;
    logic [WIDTH-1:0]  a_q, b_q, c_q;
    logic [1:0]        mode_q;
    logic [RWIDTH-1:0] product_q;
    logic [CW-1:0]     count_q;
    logic [RWIDTH-1:0] result_q;
    logic              consume_q;
    logic [RWIDTH-1:0] ea, eb, ec, lo_ab, hi_ab, calc_d;

    assign capture = (state_q == IDLE) && bus.done &&
                     bus.r0_valid && bus.r1_valid && bus.r2_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (capture) state_d = (bus.op_mode == 2'b00) ? MUL : CALC;
            MUL:  if (count_q == LAST_BIT) state_d = CALC;
            CALC: state_d = OUT;
            OUT:  if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result function of the latched operands, evaluated in CALC.
    always_comb begin
        ea     = RWIDTH'(a_q);
        eb     = RWIDTH'(b_q);
        ec     = RWIDTH'(c_q);
        lo_ab  = (ea < eb) ? ea : eb;
        hi_ab  = (ea > eb) ? ea : eb;
        calc_d = '0;
        case (mode_q)
            2'b00: calc_d = product_q + ec;
            2'b01: calc_d = ea + eb + ec;
            2'b10: calc_d = (lo_ab < ec) ? lo_ab : ec;
            2'b11: calc_d = (hi_ab > ec) ? hi_ab : ec;
            default: calc_d = '0;
        endcase
    end

    // Operand capture, shift-add multiply, result register and consume pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            mode_q    <= '0;
            product_q <= '0;
            count_q   <= '0;
            result_q  <= '0;
            consume_q <= 1'b0;
        end else begin
            consume_q <= capture;
            if (capture) begin
                a_q       <= bus.r0;
                b_q       <= bus.r1;
                c_q       <= bus.r2;
                mode_q    <= bus.op_mode;
                product_q <= '0;
                count_q   <= '0;
            end
            if (state_q == MUL) begin
                if (b_q[count_q])
                    product_q <= product_q + (RWIDTH'(a_q) << count_q);
                count_q <= count_q + 1'b1;
            end
            if (state_q == CALC)
                result_q <= calc_d;
        end
    end

    assign bus.consume      = consume_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = (state_q == OUT);
    assign bus.result       = result_q;
endmodule

// File: tb/tb_operand_combiner.sv
// Directed self-checking bench for operand_combiner.
module tb_operand_combiner;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total = 0;

    operand_combiner_if #(.WIDTH(8), .RWIDTH(16)) bus ();

    operand_combiner #(.WIDTH(8), .RWIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a full triple with done for one edge, then drop done.
    task automatic capture(input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c);
        bus.op_mode  = op;
        bus.r0 = a; bus.r1 = b; bus.r2 = c;
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1; bus.r2_valid = 1'b1;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    // Bounded wait for result_valid; reports edges taken (max on timeout).
    task automatic wait_valid(input int max_edges, output int edges);
        edges = 0;
        while (!bus.result_valid && edges < max_edges) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.consume !== 1'b0) $display("FAIL reset_consume got=%b exp=0", bus.consume); else passed++;
        total++; if (bus.result_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.result_valid); else passed++;
        total++; if (bus.result !== 16'd0) $display("FAIL reset_result got=%0d exp=0", bus.result); else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mac();
        bus.result_ready = 1'b1;
        capture(2'b00, 8'd10, 8'd20, 8'd30);
        total++; if (bus.consume !== 1'b1) $display("FAIL mac_consume got=%b exp=1", bus.consume); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL mac_busy got=%b exp=1", bus.busy); else passed++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++;
            if (bus.result_valid !== (k == 9))
                $display("FAIL mac_latency edge=%0d got=%b exp=%b", k, bus.result_valid, (k == 9));
            else passed++;
            if (k == 1) begin
                total++; if (bus.consume !== 1'b0) $display("FAIL mac_consume_pulse got=%b exp=0", bus.consume); else passed++;
            end
        end
        total++; if (bus.result !== 16'd230) $display("FAIL mac_result got=%0d exp=230", bus.result); else passed++;
        tick();
        total++; if (bus.result_valid !== 1'b0) $display("FAIL mac_hs_valid got=%b exp=0", bus.result_valid); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mac_hs_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.result !== 16'd230) $display("FAIL mac_hs_result_hold got=%0d exp=230", bus.result); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.result_ready = 1'b1;
        capture(2'b01, 8'd40, 8'd50, 8'd60);
        total++; if (bus.consume !== 1'b1) $display("FAIL sum_consume got=%b exp=1", bus.consume); else passed++;
        tick();
        total++; if (bus.result_valid !== 1'b1) $display("FAIL sum_valid got=%b exp=1", bus.result_valid); else passed++;
        total++; if (bus.result !== 16'd150) $display("FAIL sum_result got=%0d exp=150", bus.result); else passed++;
        total++; if (bus.consume !== 1'b0) $display("FAIL sum_consume_once got=%b exp=0", bus.consume); else passed++;
        tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL sum_hs_busy got=%b exp=0", bus.busy); else passed++;
        capture(2'b11, 8'd40, 8'd50, 8'd60);
        total++; if (bus.consume !== 1'b1) $display("FAIL max_consume got=%b exp=1", bus.consume); else passed++;
        tick();
        total++; if (bus.result !== 16'd60) $display("FAIL max_result got=%0d exp=60", bus.result); else passed++;
        total++; if (bus.consume !== 1'b0) $display("FAIL max_consume_once got=%b exp=0", bus.consume); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int edges;
        bus.result_ready = 1'b0;
        capture(2'b00, 8'd255, 8'd255, 8'd255);
        wait_valid(20, edges);
        total++; if (edges !== 9) $display("FAIL bp_latency got=%0d exp=9", edges); else passed++;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.op_mode = 2'b01;
                bus.r0 = 8'd1; bus.r1 = 8'd2; bus.r2 = 8'd3;
                bus.done = 1'b1;
            end
            tick();
            total++; if (bus.result_valid !== 1'b1) $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", k, bus.result_valid); else passed++;
            total++; if (bus.result !== 16'd65280) $display("FAIL bp_result_hold cyc=%0d got=%0d exp=65280", k, bus.result); else passed++;
            total++; if (bus.consume !== 1'b0) $display("FAIL bp_no_consume cyc=%0d got=%b exp=0", k, bus.consume); else passed++;
        end
        bus.result_ready = 1'b1;
        tick();
        total++; if (bus.result_valid !== 1'b0) $display("FAIL bp_hs_valid got=%b exp=0", bus.result_valid); else passed++;
        total++; if (bus.consume !== 1'b0) $display("FAIL bp_hs_consume got=%b exp=0", bus.consume); else passed++;
        tick();
        bus.done = 1'b0;
        total++; if (bus.consume !== 1'b1) $display("FAIL bp_second_consume got=%b exp=1", bus.consume); else passed++;
        tick();
        total++; if (bus.result !== 16'd6) $display("FAIL bp_second_result got=%0d exp=6", bus.result); else passed++;
        tick();
    endtask

    task automatic test_partial();
        bus.result_ready = 1'b1;
        bus.op_mode = 2'b01;
        bus.r0 = 8'd1; bus.r1 = 8'd1; bus.r2 = 8'd1;
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1; bus.r2_valid = 1'b0;
        bus.done = 1'b1;
        tick(); tick();
        total++; if (bus.consume !== 1'b0) $display("FAIL partial_consume got=%b exp=0", bus.consume); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL partial_busy got=%b exp=0", bus.busy); else passed++;
        bus.r2_valid = 1'b1;
        tick();
        bus.done = 1'b0;
        total++; if (bus.consume !== 1'b1) $display("FAIL partial_capture got=%b exp=1", bus.consume); else passed++;
        tick();
        total++; if (bus.result !== 16'd3) $display("FAIL partial_result got=%0d exp=3", bus.result); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int edges;
        bus.result_ready = 1'b1;
        capture(2'b00, 8'd3, 8'd4, 8'd5);
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.consume !== 1'b0) $display("FAIL rst_mid_consume got=%b exp=0", bus.consume); else passed++;
        total++; if (bus.result_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", bus.result_valid); else passed++;
        total++; if (bus.result !== 16'd0) $display("FAIL rst_mid_result got=%0d exp=0", bus.result); else passed++;
        reset = 1'b1;
        tick();
        capture(2'b00, 8'd3, 8'd4, 8'd5);
        wait_valid(20, edges);
        total++; if (edges !== 9) $display("FAIL rst_mac_latency got=%0d exp=9", edges); else passed++;
        total++; if (bus.result !== 16'd17) $display("FAIL rst_mac_result got=%0d exp=17", bus.result); else passed++;
        tick();
    endtask

    task automatic test_min();
        bus.result_ready = 1'b1;
        capture(2'b10, 8'd0, 8'd7, 8'd0);
        tick();
        total++; if (bus.result !== 16'd0) $display("FAIL min_zero got=%0d exp=0", bus.result); else passed++;
        tick();
        capture(2'b10, 8'd9, 8'd9, 8'd9);
        tick();
        total++; if (bus.result !== 16'd9) $display("FAIL min_equal got=%0d exp=9", bus.result); else passed++;
        total++; if (bus.result_valid !== 1'b1) $display("FAIL min_valid got=%b exp=1", bus.result_valid); else passed++;
        tick();
    endtask

    initial begin
        bus.op_mode = 2'b00;
        bus.r0 = '0; bus.r1 = '0; bus.r2 = '0;
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.r2_valid = 1'b0;
        bus.done = 1'b0;
        bus.result_ready = 1'b0;
        test_reset();
        test_mac();
        test_back_to_back();
        test_backpressure();
        test_partial();
        test_reset_mid_op();
        test_min();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
